// File: rtl/instruction_fetch_controller.sv
// rtl/instruction_fetch_controller.sv - byte-serial instruction fetch FSM with redirect and fault handling
// Assembles 32-bit little-endian instructions from a one-cycle-latency byte memory.
module instruction_fetch_controller #(
   parameter logic [63:0] RESET_PC  = 64'd0,
   parameter int unsigned MEM_BYTES = 72
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Fetch_En,
   output logic [63:0] Mem_Addr,
   output logic        Mem_Rd_En,
   input  logic [7:0]  Mem_Data,
   output logic [31:0] Instruction,
   output logic [63:0] Inst_PC,
   output logic        Inst_Valid,
   input  logic        Inst_Ready,
   input  logic        Redirect_Valid,
   input  logic [63:0] Redirect_PC,
   output logic        Fault
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      FAULT = 2'd3
   } state_t;

   localparam logic [64:0] MEM_LIMIT = 65'(MEM_BYTES);

   state_t      state, state_next;
   logic [63:0] pc, pc_next;
   logic [2:0]  cnt, cnt_next;
   logic [31:0] instr, instr_next;
   logic [63:0] inst_pc, inst_pc_next;
   logic [63:0] pc_plus4;
   logic [63:0] addr_c;
   logic        rd_en_c;

   // Range check uses 65 bits so PC+3 cannot wrap back into the valid window.
   function automatic logic pc_bad(input logic [63:0] p);
      return (p[1:0] != 2'b00) || (({1'b0, p} + 65'd3) >= MEM_LIMIT);
   endfunction

   assign pc_plus4 = pc + 64'd4;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         cnt     <= 3'd0;
         instr   <= 32'd0;
         inst_pc <= 64'd0;
      end else begin
         state   <= state_next;
         pc      <= pc_next;
         cnt     <= cnt_next;
         instr   <= instr_next;
         inst_pc <= inst_pc_next;
      end
   end

   always_comb begin
      state_next   = state;
      pc_next      = pc;
      cnt_next     = cnt;
      instr_next   = instr;
      inst_pc_next = inst_pc;
      rd_en_c      = 1'b0;
      addr_c       = 64'd0;

      case (state)
         IDLE: begin
            if (Fetch_En) begin
               cnt_next   = 3'd0;
               state_next = pc_bad(pc) ? FAULT : FETCH;
            end
         end
         FETCH: begin
            // Requests go out in cycles 0..3; each byte lands one cycle later.
            if (cnt < 3'd4) begin
               rd_en_c = 1'b1;
               addr_c  = pc + {61'd0, cnt};
            end
            case (cnt)
               3'd1:    instr_next[7:0]   = Mem_Data;
               3'd2:    instr_next[15:8]  = Mem_Data;
               3'd3:    instr_next[23:16] = Mem_Data;
               3'd4:    instr_next[31:24] = Mem_Data;
               default: ;
            endcase
            if (cnt == 3'd4) begin
               state_next   = HOLD;
               inst_pc_next = pc;
               cnt_next     = 3'd0;
            end else begin
               cnt_next = cnt + 3'd1;
            end
         end
         HOLD: begin
            if (Inst_Ready) begin
               pc_next  = pc_plus4;
               cnt_next = 3'd0;
               if (Fetch_En) state_next = pc_bad(pc_plus4) ? FAULT : FETCH;
               else          state_next = IDLE;
            end
         end
         FAULT: ;
         default: state_next = IDLE;
      endcase

      // Redirect wins over everything; partial bytes and any pending handshake are dropped.
      if (Redirect_Valid) begin
         pc_next      = Redirect_PC;
         cnt_next     = 3'd0;
         instr_next   = instr;
         inst_pc_next = inst_pc;
         if (pc_bad(Redirect_PC) && (Fetch_En || state == FAULT)) state_next = FAULT;
         else if (Fetch_En)                                       state_next = FETCH;
         else                                                     state_next = IDLE;
      end
   end

   assign Mem_Addr    = addr_c;
   assign Mem_Rd_En   = rd_en_c;
   assign Instruction = instr;
   assign Inst_PC     = inst_pc;
   assign Inst_Valid  = (state == HOLD);
   assign Fault       = (state == FAULT);

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// tb/tb_instruction_fetch_controller.sv - scoreboard bench for instruction_fetch_controller
// Byte memory model with one-cycle read latency; handshakes are checked against a queue.
module tb_instruction_fetch_controller;

   logic        clk;
   logic        reset;
   logic        Fetch_En;
   logic [63:0] Mem_Addr;
   logic        Mem_Rd_En;
   logic [7:0]  Mem_Data;
   logic [31:0] Instruction;
   logic [63:0] Inst_PC;
   logic        Inst_Valid;
   logic        Inst_Ready;
   logic        Redirect_Valid;
   logic [63:0] Redirect_PC;
   logic        Fault;

   logic [7:0]  mem [0:71];
   logic [95:0] exp_q [$];
   int checks = 0;
   int errors = 0;

   instruction_fetch_controller #(.RESET_PC(64'd0), .MEM_BYTES(72)) dut (
      .clk(clk), .reset(reset), .Fetch_En(Fetch_En),
      .Mem_Addr(Mem_Addr), .Mem_Rd_En(Mem_Rd_En), .Mem_Data(Mem_Data),
      .Instruction(Instruction), .Inst_PC(Inst_PC), .Inst_Valid(Inst_Valid),
      .Inst_Ready(Inst_Ready), .Redirect_Valid(Redirect_Valid),
      .Redirect_PC(Redirect_PC), .Fault(Fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (Mem_Rd_En) Mem_Data <= (Mem_Addr < 64'd72) ? mem[Mem_Addr[6:0]] : 8'h00;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: every accepted instruction must match the oldest expectation.
   always @(negedge clk) begin
      if (reset && Inst_Valid && Inst_Ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_inst: got pc %h instr %h, expected none", Inst_PC, Instruction);
         end else begin
            logic [95:0] e;
            e = exp_q.pop_front();
            check("sb_instr", {32'd0, Instruction}, {32'd0, e[95:64]});
            check("sb_pc", Inst_PC, e[63:0]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!Inst_Valid && n < 20) begin
         step();
         n++;
      end
      check(name, {63'd0, Inst_Valid}, 64'd1);
   endtask

   task automatic expect_inst(input logic [31:0] ins, input logic [63:0] pc);
      exp_q.push_back({ins, pc});
   endtask

   initial begin
      for (int i = 0; i < 72; i++) mem[i] = 8'(i);
      mem[0] = 8'h63; mem[1] = 8'h84; mem[2] = 8'hBD; mem[3] = 8'h04;
      Mem_Data = 8'h00;
      reset = 1'b0; Fetch_En = 1'b0; Inst_Ready = 1'b0;
      Redirect_Valid = 1'b0; Redirect_PC = 64'd0;
      step(); step();
      check("rst_valid", {63'd0, Inst_Valid}, 64'd0);
      check("rst_rd_en", {63'd0, Mem_Rd_En}, 64'd0);
      check("rst_addr", Mem_Addr, 64'd0);
      check("rst_fault", {63'd0, Fault}, 64'd0);
      check("rst_instr", {32'd0, Instruction}, 64'd0);
      check("rst_inst_pc", Inst_PC, 64'd0);
      reset = 1'b1;
      step();

      // First fetch: exact five-cycle latency and byte addresses 0..3.
      expect_inst(32'h04BD8463, 64'd0);
      Fetch_En = 1'b1; Inst_Ready = 1'b1;
      step();
      for (int k = 0; k < 4; k++) begin
         check("fetch0_rd_en", {63'd0, Mem_Rd_En}, 64'd1);
         check("fetch0_addr", Mem_Addr, 64'(k));
         step();
      end
      check("fetch0_cap_rd_en", {63'd0, Mem_Rd_En}, 64'd0);
      check("fetch0_not_valid", {63'd0, Inst_Valid}, 64'd0);
      step();
      check("fetch0_valid_at_5", {63'd0, Inst_Valid}, 64'd1);
      check("fetch0_instr", {32'd0, Instruction}, 64'h04BD8463);
      step();
      check("next_addr", Mem_Addr, 64'd4);
      check("next_valid_low", {63'd0, Inst_Valid}, 64'd0);

      // Backpressure in HOLD.
      Inst_Ready = 1'b0;
      expect_inst(32'h07060504, 64'd4);
      wait_valid("hold_reach");
      for (int k = 0; k < 3; k++) begin
         step();
         check("hold_valid", {63'd0, Inst_Valid}, 64'd1);
         check("hold_rd_en", {63'd0, Mem_Rd_En}, 64'd0);
         check("hold_instr", {32'd0, Instruction}, 64'h07060504);
         check("hold_pc", Inst_PC, 64'd4);
      end
      Inst_Ready = 1'b1;
      step();
      check("after_hs_valid", {63'd0, Inst_Valid}, 64'd0);
      check("after_hs_addr", Mem_Addr, 64'd8);

      // Redirect on the 2nd fetch cycle of PC 8.
      step();
      Redirect_Valid = 1'b1; Redirect_PC = 64'h20;
      step();
      Redirect_Valid = 1'b0;
      check("redir_addr", Mem_Addr, 64'h20);
      check("redir_valid", {63'd0, Inst_Valid}, 64'd0);
      expect_inst(32'h23222120, 64'h20);
      wait_valid("redir_reach");
      step();

      // Redirect to misaligned target faults; bad redirect in FAULT stays.
      step();
      Redirect_Valid = 1'b1; Redirect_PC = 64'h22;
      step();
      Redirect_Valid = 1'b0;
      check("fault_set", {63'd0, Fault}, 64'd1);
      check("fault_rd_en", {63'd0, Mem_Rd_En}, 64'd0);
      check("fault_valid", {63'd0, Inst_Valid}, 64'd0);
      step();
      check("fault_sticky", {63'd0, Fault}, 64'd1);
      Redirect_Valid = 1'b1; Redirect_PC = 64'h2A;
      step();
      check("fault_bad_redir", {63'd0, Fault}, 64'd1);
      Redirect_PC = 64'h10;
      step();
      Redirect_Valid = 1'b0;
      check("fault_clear", {63'd0, Fault}, 64'd0);
      check("fault_exit_addr", Mem_Addr, 64'h10);
      check("fault_exit_rd", {63'd0, Mem_Rd_En}, 64'd1);
      expect_inst(32'h13121110, 64'h10);

      // Dropping Fetch_En mid-fetch completes the fetch, then idles.
      step();
      Fetch_En = 1'b0;
      wait_valid("noabort_reach");
      step();
      check("idle_rd_en", {63'd0, Mem_Rd_En}, 64'd0);
      step();
      check("idle_valid", {63'd0, Inst_Valid}, 64'd0);

      // Sequential fetch to the top of memory, then range fault at 72.
      Fetch_En = 1'b1; Redirect_Valid = 1'b1; Redirect_PC = 64'd64;
      expect_inst(32'h43424140, 64'd64);
      expect_inst(32'h47464544, 64'd68);
      step();
      Redirect_Valid = 1'b0;
      check("top_addr", Mem_Addr, 64'd64);
      wait_valid("top64_reach");
      step();
      wait_valid("top68_reach");
      step();
      check("range_fault", {63'd0, Fault}, 64'd1);
      check("range_rd_en", {63'd0, Mem_Rd_En}, 64'd0);

      // Reset mid-fetch, then restart at RESET_PC.
      Redirect_Valid = 1'b1; Redirect_PC = 64'd8;
      step();
      Redirect_Valid = 1'b0;
      step(); step();
      reset = 1'b0;
      step();
      check("mid_rst_rd_en", {63'd0, Mem_Rd_En}, 64'd0);
      check("mid_rst_addr", Mem_Addr, 64'd0);
      check("mid_rst_valid", {63'd0, Inst_Valid}, 64'd0);
      check("mid_rst_fault", {63'd0, Fault}, 64'd0);
      check("mid_rst_instr", {32'd0, Instruction}, 64'd0);
      check("mid_rst_inst_pc", Inst_PC, 64'd0);
      reset = 1'b1;
      expect_inst(32'h04BD8463, 64'd0);
      step();
      check("restart_addr", Mem_Addr, 64'd0);
      check("restart_rd_en", {63'd0, Mem_Rd_En}, 64'd1);
      wait_valid("restart_reach");
      Fetch_En = 1'b0;
      step();
      step();
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
